alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one ALU core between two requesters (port 0, port 1). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the winning command and operands, and drives a single-cycle enable pulse to the ALU. It then waits a fixed ALU latency, captures the result and returns it to the granted requester. It sits between instruction-decode/requester logic and the ALU core's i_en/i_cmd/i_da/i_db inputs.

Parameters:
I_BW, 4, command (instruction) width
D_BW, 4, operand/result data width
ALU_LAT, 1, cycles from the alu_en pulse to valid alu_res; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_cmd  in  I_BW  port 0 command
req0_da  in  D_BW  port 0 operand A
req0_db  in  D_BW  port 0 operand B
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 result consumed
rsp0_data  out  D_BW  port 0 result
req1_valid/req1_ready/req1_cmd/req1_da/req1_db  same as port 0, for port 1
rsp1_valid/rsp1_ready/rsp1_data  same as port 0, for port 1
alu_en  out  1  ALU enable, one-cycle pulse per operation
alu_cmd  out  I_BW  ALU command, registered
alu_da  out  D_BW  ALU operand A, registered
alu_db  out  D_BW  ALU operand B, registered
alu_res  in  D_BW  ALU result, sampled ALU_LAT cycles after alu_en

Behaviour:
- Reset (async assert, sync-release use):
  - FSM goes to IDLE.
  - last_grant is set to 1, so port 0 wins first.
  - alu_en, alu_cmd, alu_da, alu_db, rsp*_valid, rsp*_data, the latency counter and the result register all reset to 0.
- Reset mid-operation: the operation is aborted silently and no response is produced. Requesters must reissue.
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one operation is outstanding.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, that port wins. If both are high, the port != last_grant wins.
  - reqN_ready = 1 only for the granted port, and only in IDLE. It is 0 in all other states.
  - On handshake (valid & ready), register cmd/da/db into alu_cmd/alu_da/alu_db, store the grant index, and go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - alu_en = 1 for exactly this cycle.
  - Load the counter with ALU_LAT-1 and go to WAIT.
- WAIT:
  - If the counter is 0, capture alu_res into the result register and go to RESP.
  - Otherwise decrement the counter.
  - alu_res is therefore sampled exactly ALU_LAT cycles after the alu_en cycle.
- RESP:
  - rsp_valid of the granted port = 1, with rsp_data = the result register.
  - The other port's rsp_valid stays 0.
  - Hold until rsp_ready of the granted port. On that handshake: drop rsp_valid, set last_grant = the granted index, go to IDLE.
- alu_cmd/alu_da/alu_db hold their values between operations; only alu_en pulses.
- rspN_data holds its last value when rspN_valid = 0. It is only updated on capture, and only for the granted port.
- Latency from request handshake cycle T to rsp_valid rising: T + ALU_LAT + 2.
  - Minimum occupancy per operation is ALU_LAT + 3 cycles when rsp_ready is held high.
- Simultaneous events:
  - A request arriving during ISSUE/WAIT/RESP waits; it is not lost, because the requester holds valid.
  - A request and a response in the same cycle cannot overlap, because the design allows one outstanding operation.
- Requests must stay stable while valid and not ready. The block does not check this.
- No combinational path from alu_res to any output. rsp_valid and the alu_* outputs are registered.
- Starvation-free: with both ports continuously valid, grants alternate 0,1,0,1.

Decomposition:
- Package alu_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  - localparam CNT_W = 4.
- One natural sub-module: alu_rr_arb2, a 2-way round-robin grant with last_grant register.
  - Inputs: req[1:0], advance.
  - Output: grant index plus grant-valid.
- Requester channel signals can later be bundled into an interface alongside the ALU core interface.

Test Plan:
- Single request, ALU_LAT=1: port 0 sends cmd=4'h3, da=4'h5, db=4'h2 at cycle 0 with rsp0_ready=1; ALU model returns da+db.
  - alu_en high at cycle 1 only, with alu_cmd=3, alu_da=5, alu_db=2.
  - rsp0_valid at cycle 3 with rsp0_data=4'h7.
  - rsp1_valid stays 0.
- Contention: both ports valid continuously from reset, each carrying 4 ops.
  - Grant order is 0,1,0,1,0,1,0,1.
  - Each response goes only to its own port.
- Response backpressure: hold rsp1_ready=0 for 5 cycles after rsp1_valid rises.
  - rsp1_valid and rsp1_data stay stable.
  - req0_ready stays 0 throughout.
  - IDLE is re-entered the cycle after rsp1_ready=1.
- ALU_LAT=4 build: check alu_res is sampled exactly 4 cycles after alu_en.
  - Use a model that drives the correct value only in that cycle and 4'hF otherwise.
  - The response must equal the correct value.
- Reset mid-WAIT: assert rst_n=0 during WAIT.
  - All outputs go to 0 asynchronously.
  - After release, no rsp*_valid appears, and the next request is granted to port 0.
- Idle hold: no requests for 20 cycles.
  - alu_en stays 0 and alu_cmd/alu_da/alu_db keep the last operation's values.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
`default_nettype none

package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// Requester request/response channels for both ports plus the ALU core command/result bus.
`default_nettype none

interface alu_arbiter_if #(
  parameter int I_BW = 4,
  parameter int D_BW = 4
);

  logic            req0_valid;
  logic            req0_ready;
  logic [I_BW-1:0] req0_cmd;
  logic [D_BW-1:0] req0_da;
  logic [D_BW-1:0] req0_db;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [D_BW-1:0] rsp0_data;

  logic            req1_valid;
  logic            req1_ready;
  logic [I_BW-1:0] req1_cmd;
  logic [D_BW-1:0] req1_da;
  logic [D_BW-1:0] req1_db;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [D_BW-1:0] rsp1_data;

  logic            alu_en;
  logic [I_BW-1:0] alu_cmd;
  logic [D_BW-1:0] alu_da;
  logic [D_BW-1:0] alu_db;
  logic [D_BW-1:0] alu_res;

  // master: requesters and ALU core side; slave: the arbiter
  modport master (
    output req0_valid, req0_cmd, req0_da, req0_db, rsp0_ready,
    output req1_valid, req1_cmd, req1_da, req1_db, rsp1_ready,
    output alu_res,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  alu_en, alu_cmd, alu_da, alu_db
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_da, req0_db, rsp0_ready,
    input  req1_valid, req1_cmd, req1_da, req1_db, rsp1_ready,
    input  alu_res,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output alu_en, alu_cmd, alu_da, alu_db
  );

endinterface

`default_nettype wire

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant; last_grant advances only when an operation completes.
`default_nettype none

module alu_rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] req_i,
  input  wire logic       advance_i,
  input  wire logic       adv_idx_i,
  output logic            grant_o,
  output logic            grant_valid_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i) begin
      last_grant_d = adv_idx_i;
    end
  end

  // Reset to 1 so port 0 wins the first contended grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grant_valid_o = |req_i;
    grant_o       = 1'b0;
    case (req_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_q;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// Shares one ALU core between two valid/ready requesters with round-robin arbitration
// and a single outstanding operation of fixed ALU latency.
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int I_BW    = 4,
  parameter int D_BW    = 4,
  parameter int ALU_LAT = 1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] C_LAT_M1 = CNT_W'(ALU_LAT - 1);

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic            gnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [I_BW-1:0] alu_cmd_q;
  logic [D_BW-1:0] alu_da_q;
  logic [D_BW-1:0] alu_db_q;
  logic [D_BW-1:0] rsp0_data_q;
  logic [D_BW-1:0] rsp1_data_q;

  logic       w_gnt;
  logic       w_gnt_vld;
  logic       w_accept;
  logic       w_rsp_hs;
  logic       w_req0_rdy;
  logic       w_req1_rdy;
  logic       w_alu_en;
  logic [1:0] w_rsp_vld;

  alu_rr_arb2 u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         ({bus.req1_valid, bus.req0_valid}),
    .advance_i     (w_rsp_hs),
    .adv_idx_i     (gnt_q),
    .grant_o       (w_gnt),
    .grant_valid_o (w_gnt_vld)
  );

  assign w_accept = (state_q == IDLE) && w_gnt_vld;
  assign w_rsp_hs = (state_q == RESP) && (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_gnt_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (w_rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_req0_rdy = 1'b0;
    w_req1_rdy = 1'b0;
    w_alu_en   = 1'b0;
    w_rsp_vld  = 2'b00;
    case (state_q)
      IDLE: begin
        w_req0_rdy = w_gnt_vld & ~w_gnt;
        w_req1_rdy = w_gnt_vld &  w_gnt;
      end
      ISSUE:   w_alu_en  = 1'b1;
      RESP:    w_rsp_vld = gnt_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Operands hold between operations; only the granted port's result register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      alu_cmd_q   <= '0;
      alu_da_q    <= '0;
      alu_db_q    <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      if (w_accept) begin
        gnt_q     <= w_gnt;
        alu_cmd_q <= w_gnt ? bus.req1_cmd : bus.req0_cmd;
        alu_da_q  <= w_gnt ? bus.req1_da  : bus.req0_da;
        alu_db_q  <= w_gnt ? bus.req1_db  : bus.req0_db;
      end
      if (state_q == ISSUE) begin
        cnt_q <= C_LAT_M1;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if ((state_q == WAIT) && (cnt_q == '0)) begin
        if (gnt_q) begin
          rsp1_data_q <= bus.alu_res;
        end else begin
          rsp0_data_q <= bus.alu_res;
        end
      end
    end
  end

  assign bus.req0_ready = w_req0_rdy;
  assign bus.req1_ready = w_req1_rdy;
  assign bus.rsp0_valid = w_rsp_vld[0];
  assign bus.rsp1_valid = w_rsp_vld[1];
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.alu_en     = w_alu_en;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.alu_da     = alu_da_q;
  assign bus.alu_db     = alu_db_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Two arbiter builds (ALU latency 1 and 4) driven side by side against a transaction-level model.
`default_nettype none

module tb_alu_arbiter;

  localparam int M_IDLE = 0;
  localparam int M_ONE  = 1;
  localparam int M_CONT = 2;
  localparam int M_BP   = 3;
  localparam int M_RAND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.I_BW(4), .D_BW(4)) b1 ();
  alu_arbiter_if #(.I_BW(4), .D_BW(4)) b4 ();

  alu_arbiter #(.I_BW(4), .D_BW(4), .ALU_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  alu_arbiter #(.I_BW(4), .D_BW(4), .ALU_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  // stimulus, index [k] = build (0: latency 1, 1: latency 4), [p] = port
  logic [1:0] rv [2];
  logic [1:0] sr [2];
  logic [3:0] rcmd [2][2];
  logic [3:0] rda  [2][2];
  logic [3:0] rdb  [2][2];
  logic [3:0] ares [2];

  // observed DUT outputs
  logic [1:0]  rr [2];
  logic [1:0]  sv [2];
  logic [3:0]  sd [2][2];
  logic [1:0]  en;
  logic [11:0] aop [2];

  assign b1.req0_valid = rv[0][0];  assign b1.req1_valid = rv[0][1];
  assign b1.req0_cmd = rcmd[0][0];  assign b1.req1_cmd = rcmd[0][1];
  assign b1.req0_da  = rda[0][0];   assign b1.req1_da  = rda[0][1];
  assign b1.req0_db  = rdb[0][0];   assign b1.req1_db  = rdb[0][1];
  assign b1.rsp0_ready = sr[0][0];  assign b1.rsp1_ready = sr[0][1];
  assign b1.alu_res  = ares[0];
  assign b4.req0_valid = rv[1][0];  assign b4.req1_valid = rv[1][1];
  assign b4.req0_cmd = rcmd[1][0];  assign b4.req1_cmd = rcmd[1][1];
  assign b4.req0_da  = rda[1][0];   assign b4.req1_da  = rda[1][1];
  assign b4.req0_db  = rdb[1][0];   assign b4.req1_db  = rdb[1][1];
  assign b4.rsp0_ready = sr[1][0];  assign b4.rsp1_ready = sr[1][1];
  assign b4.alu_res  = ares[1];

  assign rr[0] = {b1.req1_ready, b1.req0_ready};
  assign rr[1] = {b4.req1_ready, b4.req0_ready};
  assign sv[0] = {b1.rsp1_valid, b1.rsp0_valid};
  assign sv[1] = {b4.rsp1_valid, b4.rsp0_valid};
  assign sd[0][0] = b1.rsp0_data;  assign sd[0][1] = b1.rsp1_data;
  assign sd[1][0] = b4.rsp0_data;  assign sd[1][1] = b4.rsp1_data;
  assign en = {b4.alu_en, b1.alu_en};
  assign aop[0] = {b1.alu_cmd, b1.alu_da, b1.alu_db};
  assign aop[1] = {b4.alu_cmd, b4.alu_da, b4.alu_db};

  // ALU core behaviour: cmd[3:2] selects add/sub/xor/and
  function automatic logic [3:0] alu_f(input logic [11:0] o);
    logic [3:0] a;
    logic [3:0] b;
    a = o[7:4];
    b = o[3:0];
    case (o[11:10])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // ALU result is correct only exactly LAT cycles after alu_en, 4'hF otherwise
  logic       d1;
  logic [3:0] d4;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 1'b0;
      d4 <= 4'h0;
    end else begin
      d1 <= en[0];
      d4 <= {d4[2:0], en[1]};
    end
  end
  assign ares[0] = d1    ? alu_f(aop[0]) : 4'hF;
  assign ares[1] = d4[3] ? alu_f(aop[1]) : 4'hF;

  // reference model state
  bit          busy [2];
  bit          gp   [2];
  bit          last [2];
  int          tcy  [2];
  logic [11:0] op   [2];
  logic [3:0]  res  [2];
  logic [3:0]  hold [2][2];
  int          ndone [2];
  int          nacc  [2][2];
  int          bpcnt [2];
  int          gl [2][16];
  int          gn [2];
  int          cyc;
  int          mode;
  int          nchk;
  int          npass;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic string tg(input string s, input int k);
    return $sformatf("%s[L%0d]", s, lat(k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic newop(input int k, input int p);
    rcmd[k][p] = 4'($urandom);
    rda[k][p]  = 4'($urandom);
    rdb[k][p]  = 4'($urandom);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0;
      gp[k]   = 1'b0;
      last[k] = 1'b1;
      tcy[k]  = 0;
      op[k]   = 12'h000;
      res[k]  = 4'h0;
      hold[k][0] = 4'h0;
      hold[k][1] = 4'h0;
    end
  endtask

  task automatic stim(input int k, input logic [1:0] hs, input logic [1:0] ev);
    for (int p = 0; p < 2; p++) begin
      case (mode)
        M_IDLE: begin
          rv[k][p] = 1'b0;
          sr[k][p] = 1'b1;
        end
        M_ONE: begin
          if (hs[p]) rv[k][p] = 1'b0;
          sr[k][p] = 1'b1;
        end
        M_CONT: begin
          sr[k][p] = 1'b1;
          if (hs[p]) begin
            nacc[k][p]++;
            rv[k][p] = (nacc[k][p] < 4);
            newop(k, p);
          end
        end
        M_BP: begin
          if (p == 0) begin
            sr[k][0] = 1'b1;
            if (hs[0]) rv[k][0] = 1'b0;
            if (hs[1]) begin
              rv[k][0] = 1'b1;
              newop(k, 0);
            end
          end else begin
            if (ev[1]) bpcnt[k]++;
            sr[k][1] = (bpcnt[k] >= 5);
            if (hs[1]) rv[k][1] = 1'b0;
          end
        end
        default: begin
          sr[k][p] = ($urandom_range(0, 3) != 0);
          if (hs[p] || !rv[k][p]) begin
            rv[k][p] = ($urandom_range(0, 2) == 0);
            newop(k, p);
          end
        end
      endcase
    end
  endtask

  // One clock: check at the falling edge, advance the model after the rising edge
  task automatic cycle();
    logic [1:0] erdy [2];
    logic [1:0] ersp [2];
    logic [1:0] hs   [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      erdy[k] = 2'b00;
      if (!busy[k]) begin
        case (rv[k])
          2'b01:   erdy[k] = 2'b01;
          2'b10:   erdy[k] = 2'b10;
          2'b11:   erdy[k] = last[k] ? 2'b01 : 2'b10;
          default: erdy[k] = 2'b00;
        endcase
      end
      if (busy[k] && (cyc == tcy[k] + lat(k) + 2)) hold[k][gp[k]] = res[k];
      ersp[k] = (busy[k] && (cyc >= tcy[k] + lat(k) + 2)) ? (gp[k] ? 2'b10 : 2'b01) : 2'b00;
      chk(tg("req_ready", k), 32'(rr[k]), 32'(erdy[k]));
      chk(tg("alu_en", k), 32'(en[k]), 32'(busy[k] && (cyc == tcy[k] + 1)));
      chk(tg("alu_ops", k), 32'(aop[k]), 32'(op[k]));
      chk(tg("rsp_valid", k), 32'(sv[k]), 32'(ersp[k]));
      chk(tg("rsp0_data", k), 32'(sd[k][0]), 32'(hold[k][0]));
      chk(tg("rsp1_data", k), 32'(sd[k][1]), 32'(hold[k][1]));
      hs[k] = erdy[k] & rv[k];
      if (((rr[k] & rv[k]) != 2'b00) && (gn[k] < 16)) begin
        gl[k][gn[k]] = int'(rr[k][1]);
        gn[k]++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (busy[k]) begin
        if ((ersp[k] & sr[k]) != 2'b00) begin
          busy[k] = 1'b0;
          last[k] = gp[k];
          ndone[k]++;
        end
      end else if (hs[k] != 2'b00) begin
        busy[k] = 1'b1;
        gp[k]   = hs[k][1];
        tcy[k]  = cyc;
        op[k]   = hs[k][1] ? {rcmd[k][1], rda[k][1], rdb[k][1]} : {rcmd[k][0], rda[k][0], rdb[k][0]};
        res[k]  = alu_f(op[k]);
      end
      stim(k, hs[k], ersp[k]);
    end
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (((ndone[0] < target) || (ndone[1] < target)) && (n < budget)) begin
      cycle();
      n++;
    end
    chk("ops_completed", 32'((ndone[0] >= target) && (ndone[1] >= target)), 32'd1);
  endtask

  task automatic start_phase(input int m);
    mode = m;
    for (int k = 0; k < 2; k++) begin
      ndone[k] = 0;
      gn[k]    = 0;
      bpcnt[k] = 0;
    end
  endtask

  initial begin
    int n;
    nchk = 0;
    npass = 0;
    cyc = 0;
    mode = M_IDLE;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b00;
      sr[k] = 2'b11;
      for (int p = 0; p < 2; p++) begin
        newop(k, p);
        nacc[k][p] = 0;
      end
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // contention from reset: both ports hold valid for 4 ops each
    start_phase(M_CONT);
    for (int k = 0; k < 2; k++) rv[k] = 2'b11;
    rst_n = 1'b1;
    run_until(8, 300);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++)
        chk(tg("grant_order", k), 32'(gl[k][i]), 32'(i % 2));

    // single request on port 0: cmd 3, a 5, b 2
    start_phase(M_ONE);
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b01;
      rcmd[k][0] = 4'h3;
      rda[k][0]  = 4'h5;
      rdb[k][0]  = 4'h2;
    end
    run_until(1, 20);
    for (int k = 0; k < 2; k++) chk(tg("single_data", k), 32'(sd[k][0]), 32'h7);

    // response backpressure on port 1 while port 0 waits
    start_phase(M_BP);
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b10;
      sr[k] = 2'b01;
      newop(k, 1);
    end
    run_until(2, 60);

    // idle hold
    start_phase(M_IDLE);
    for (int k = 0; k < 2; k++) rv[k] = 2'b00;
    repeat (20) cycle();

    // randomized traffic, then drain
    start_phase(M_RAND);
    repeat (800) cycle();
    start_phase(M_IDLE);
    n = 0;
    while ((busy[0] || busy[1]) && (n < 60)) begin
      cycle();
      n++;
    end
    chk("drain", 32'(busy[0] || busy[1]), 32'd0);

    // reset during WAIT
    start_phase(M_ONE);
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b01;
      sr[k] = 2'b11;
      newop(k, 0);
    end
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) rv[k] = 2'b00;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(tg("rst_ctrl", k), 32'({rr[k], sv[k], en[k]}), 32'd0);
      chk(tg("rst_ops", k), 32'(aop[k]), 32'd0);
      chk(tg("rst_data", k), 32'({sd[k][0], sd[k][1]}), 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    start_phase(M_CONT);
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b11;
      nacc[k][0] = 3;
      nacc[k][1] = 3;
      newop(k, 0);
      newop(k, 1);
    end
    rst_n = 1'b1;
    run_until(2, 40);
    for (int k = 0; k < 2; k++) begin
      chk(tg("post_rst_grant0", k), 32'(gl[k][0]), 32'd0);
      chk(tg("post_rst_grant1", k), 32'(gl[k][1]), 32'd1);
    end

    start_phase(M_IDLE);
    repeat (5) cycle();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
